if_id_stall_flush_ctrl: RTL
===========================

// Module: if_id_stall_flush_ctrl
// PURPOSE
//  Consumer end of the hazard stall interface: applies PC_remain / Reg_IF_ID_remain / zero_control
//  and the EX-stage redirect flush to the front end. Owns the IF/ID pipeline register, gates PC write,
//  requests ID/EX bubbles, runs a stall/flush FSM with a consecutive-stall watchdog.
//  Sits between fetch (PC, I-mem, branch predictor) and decode; hazard unit and EX branch resolve feed it.
// PARAMETERS
//  XLEN          32           datapath / PC / instruction width
//  FLUSH_CYCLES  1            cycles IF/ID is forced to NOP per ex_flush (range 1..3)
//  MAX_STALL     15           consecutive IF/ID-hold cycles before stall_timeout asserts (>=1)
// PORTS
//  clk               in   1     rising-edge clock
//  rst_n             in   1     synchronous reset, active low
//  PC_remain         in   1     hazard unit: hold PC
//  Reg_IF_ID_remain  in   1     hazard unit: hold IF/ID contents
//  zero_control      in   1     hazard unit: zero ID control -> ID/EX bubble
//  ex_flush          in   1     EX: mispredict or jalr/jal redirect; target already on PC mux
//  if_pc             in   XLEN  fetch PC
//  if_instr          in   XLEN  fetched instruction
//  if_pred_taken     in   1     predictor decision for if_pc
//  pc_write          out  1     PC register enable
//  id_pc             out  XLEN  IF/ID PC
//  id_instr          out  XLEN  IF/ID instruction
//  id_pred_taken     out  1     IF/ID predictor bit
//  id_valid          out  1     IF/ID holds a real instruction (0 = bubble)
//  idex_bubble       out  1     force ID/EX controls to zero this cycle
//  stall_timeout     out  1     sticky: watchdog fired
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=RUN, id_pc=0, id_instr=NOP (32'h0000_0013), id_pred_taken=0,
//    id_valid=0, counters=0, stall_timeout=0. Reset mid-flush/stall aborts it; next cycle is RUN.
//  - FSM states RUN, STALL, FLUSH. Priority: ex_flush > FLUSH-in-progress > stall > normal.
//  - RUN/STALL, ex_flush=1: pc_write=1, idex_bubble=1, IF/ID<=NOP, id_valid<=0;
//    FLUSH_CYCLES>1 -> FLUSH with flush_cnt=FLUSH_CYCLES-1, else RUN.
//  - FLUSH: pc_write=1, IF/ID<=NOP, id_valid<=0, idex_bubble=1, hazard inputs ignored;
//    flush_cnt decrements, exit to RUN after the load when it reaches 1. New ex_flush reloads count.
//  - No flush: pc_write=!PC_remain; Reg_IF_ID_remain=1 -> IF/ID holds all fields (STALL),
//    else IF/ID<={if_pc,if_instr,if_pred_taken}, id_valid<=1 (RUN); idex_bubble=zero_control.
//  - pc_write, idex_bubble combinational from inputs + state (0-cycle); IF/ID 1-cycle latency.
//  - stall_cnt (width $clog2(MAX_STALL+1)): +1 per cycle Reg_IF_ID_remain honoured, saturates at
//    MAX_STALL, cleared by any non-stall cycle or flush. stall_timeout<=1 on reaching MAX_STALL; sticky.
//  - PC_remain without Reg_IF_ID_remain is legal (PC held, IF/ID advances); no assertion raised.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0], perf_flush_cycles[31:0];
//    +1 per STALL-honoured / flush-NOP cycle, wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  pipe_ctrl_pkg: NOP_INSTR constant, pipe_state_t enum {RUN,STALL,FLUSH}, XLEN default.
//  Sub-module pipe_perf_counter (enable, wrap-around 32-bit) instantiated twice under PIPE_PERF_CNT_EN.
// TESTING
//  1 Free run: 3 fetches pc 0x00/04/08 -> id_pc follows 1 cycle later, id_valid=1, pc_write=1.
//  2 Load-use: all three hazard inputs 1 for 1 cycle at pc 0x08 -> pc_write=0, idex_bubble=1,
//    id_pc stays 0x04 one extra cycle, then 0x08.
//  3 ex_flush with Reg_IF_ID_remain=1 same cycle -> flush wins: id_instr=0x00000013, id_valid=0, pc_write=1.
//  4 FLUSH_CYCLES=3: ex_flush pulse -> exactly 3 consecutive NOP loads, hazard inputs ignored, then RUN.
//  5 Reg_IF_ID_remain held 20 cycles, MAX_STALL=15 -> stall_timeout rises after 15th held edge, stays 1.
//  6 rst_n=0 during FLUSH -> all outputs at reset values next edge; PIPE_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and FSM state type for the IF/ID stall/flush controller
package pipe_ctrl_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} pipe_state_t;
endpackage

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: 32-bit wrap-around event counter with enable
module pipe_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);
  // count one per enabled cycle, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else if (en) count <= count + 32'd1;
  end
endmodule

// File: rtl/if_id_stall_flush_ctrl.sv
// if_id_stall_flush_ctrl: IF/ID register with hazard stall, EX flush and stall watchdog; PIPE_PERF_CNT_EN adds perf counters
module if_id_stall_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_remain,
  input  logic            Reg_IF_ID_remain,
  input  logic            zero_control,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  input  logic            if_pred_taken,
  output logic            pc_write,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_pred_taken,
  output logic            id_valid,
  output logic            idex_bubble,
  output logic            stall_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_cycles
`endif
);
  localparam int SW = $clog2(MAX_STALL + 1);
  pipe_state_t state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic flushing, hold;
  // state, flush countdown, stall watchdog; reset aborts any stall or flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      flush_cnt <= 2'd0;
      stall_cnt <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      stall_cnt <= stall_nxt;
      stall_timeout <= stall_timeout || stall_nxt == SW'(MAX_STALL);
    end
  end
  // next state: new flush beats an ongoing flush, which beats a hazard stall
  always_comb begin
    state_nxt = ex_flush ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
                state == FLUSH ? (flush_cnt == 2'd1 ? RUN : FLUSH) :
                hold ? STALL : RUN;
    flush_cnt_nxt = ex_flush ? 2'(FLUSH_CYCLES - 1) : state == FLUSH ? flush_cnt - 2'd1 : 2'd0;
    stall_nxt = !hold ? '0 : stall_cnt == SW'(MAX_STALL) ? stall_cnt : stall_cnt + SW'(1);
  end
  // zero-latency controls; any flush overrides the hazard unit
  always_comb begin
    flushing = ex_flush || state == FLUSH;
    hold = !flushing && Reg_IF_ID_remain;
    pc_write = flushing || !PC_remain;
    idex_bubble = flushing || zero_control;
  end
  // IF/ID register: NOP on flush, hold on stall, else capture fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_pc <= '0;
      id_instr <= XLEN'(NOP_INSTR);
      id_pred_taken <= 1'b0;
      id_valid <= 1'b0;
    end else if (flushing) begin
      id_instr <= XLEN'(NOP_INSTR);
      id_pred_taken <= 1'b0;
      id_valid <= 1'b0;
    end else if (!Reg_IF_ID_remain) begin
      id_pc <= if_pc;
      id_instr <= if_instr;
      id_pred_taken <= if_pred_taken;
      id_valid <= 1'b1;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(hold), .count(perf_stall_cycles));
  pipe_perf_counter u_flush_cnt (.clk(clk), .rst_n(rst_n), .en(flushing), .count(perf_flush_cycles));
`endif
endmodule
